// File: rtl/pong_physics.sv
// pong_physics: frame-tick driven Pong engine.
//   Moves the ball and two paddles once per frame_tick and handles wall
//   bounces, paddle hits and misses, and the serve / miss hold sequence.
//   Ball speed is latched from the level input at serve launch and on
//   every paddle hit.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame; all motion gated by it
//   start                 leaves IDLE (ignored in other states)
//   up1/down1, up2/down2  paddle controls (up = decreasing y)
//   level                 speed level
//   ball_x, ball_y        ball top-left pixel (registered)
//   paddle1_y, paddle2_y  paddle top pixel (registered)
//   miss1, miss2          one-cycle pulse when player1 / player2 misses
//   state                 00 IDLE, 01 SERVE, 10 PLAY, 11 MISS
module pong_physics #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int COORD_W       = 10,
  parameter int PADDLE1_L     = 90,
  parameter int PADDLE2_L     = 540,
  parameter int PADDLE_T      = 10,
  parameter int PADDLE_LEN    = 50,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_VEL    = 8,
  parameter int BALL_VEL_BASE = 4,
  parameter int BALL_VEL_MAX  = 12,
  parameter int LEVEL_W       = 4,
  parameter int SERVE_FRAMES  = 30,
  parameter int MISS_FRAMES   = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               up1,
  input  logic               down1,
  input  logic               up2,
  input  logic               down2,
  input  logic [LEVEL_W-1:0] level,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle1_y,
  output logic [COORD_W-1:0] paddle2_y,
  output logic               miss1,
  output logic               miss2,
  output logic [1:0]         state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_MISS  = 2'b11;

  localparam int SW         = COORD_W + 1;
  localparam int FRAMES_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W      = $clog2(FRAMES_MAX + 1);
  localparam int VS_W       = ((LEVEL_W > COORD_W) ? LEVEL_W : COORD_W) + 1;

  localparam logic [COORD_W-1:0] BALL_X0   = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_Y0   = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] PADDLE_Y0 = COORD_W'((V_RES - PADDLE_LEN) / 2);

  localparam logic signed [SW-1:0] S_ZERO = '0;
  localparam logic signed [SW-1:0] S_BS   = SW'(BALL_SIZE);
  localparam logic signed [SW-1:0] S_XMAX = SW'(H_RES - BALL_SIZE);
  localparam logic signed [SW-1:0] S_YMAX = SW'(V_RES - BALL_SIZE);
  localparam logic signed [SW-1:0] S_P1R  = SW'(PADDLE1_L + PADDLE_T);
  localparam logic signed [SW-1:0] S_P2L  = SW'(PADDLE2_L);
  localparam logic signed [SW-1:0] S_PLEN = SW'(PADDLE_LEN);
  localparam logic signed [SW-1:0] S_PVEL = SW'(PADDLE_VEL);
  localparam logic signed [SW-1:0] S_PMAX = SW'(V_RES - PADDLE_LEN);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [COORD_W-1:0] r_ball_x;
  logic [COORD_W-1:0] r_ball_y;
  logic [COORD_W-1:0] r_p1y;
  logic [COORD_W-1:0] r_p2y;
  logic [COORD_W-1:0] r_v;
  logic               r_dx_left;
  logic               r_dy_up;
  logic               r_miss1;
  logic               r_miss2;

  // Paddle step with clamping; the signed intermediate keeps y-8 from wrapping.
  function automatic logic [COORD_W-1:0] f_paddle(input logic [COORD_W-1:0] y,
                                                  input logic up, input logic dn);
    logic signed [SW-1:0] t;
    t = $signed({1'b0, y});
    if (up && !dn) begin
      t = t - S_PVEL;
      if (t < S_ZERO) t = S_ZERO;
    end else if (dn && !up) begin
      t = t + S_PVEL;
      if (t > S_PMAX) t = S_PMAX;
    end
    return t[COORD_W-1:0];
  endfunction

  // Speed for the next latch point: min(base + level, max).
  logic [VS_W-1:0]    w_lvl_sum;
  logic [COORD_W-1:0] w_lvl_v;
  assign w_lvl_sum = VS_W'(BALL_VEL_BASE) + VS_W'(level);
  assign w_lvl_v   = (w_lvl_sum > VS_W'(BALL_VEL_MAX)) ? COORD_W'(BALL_VEL_MAX)
                                                       : w_lvl_sum[COORD_W-1:0];

  logic [COORD_W-1:0] w_p1y_nxt;
  logic [COORD_W-1:0] w_p2y_nxt;
  assign w_p1y_nxt = f_paddle(r_p1y, up1, down1);
  assign w_p2y_nxt = f_paddle(r_p2y, up2, down2);

  logic signed [SW-1:0] w_bx, w_by, w_v, w_nx, w_ny, w_p1y, w_p2y;
  assign w_bx  = $signed({1'b0, r_ball_x});
  assign w_by  = $signed({1'b0, r_ball_y});
  assign w_v   = $signed({1'b0, r_v});
  assign w_p1y = $signed({1'b0, r_p1y});
  assign w_p2y = $signed({1'b0, r_p2y});
  assign w_nx  = r_dx_left ? (w_bx - w_v) : (w_bx + w_v);
  assign w_ny  = r_dy_up   ? (w_by - w_v) : (w_by + w_v);

  // Overlap uses the current ball_y and the paddle positions before this tick's move.
  logic w_ov1, w_ov2, w_hit1, w_hit2;
  assign w_ov1  = (w_by + S_BS > w_p1y) && (w_by < w_p1y + S_PLEN);
  assign w_ov2  = (w_by + S_BS > w_p2y) && (w_by < w_p2y + S_PLEN);
  assign w_hit1 = r_dx_left && (w_bx >= S_P1R) && (w_nx <= S_P1R) && w_ov1;
  assign w_hit2 = !r_dx_left && (w_bx + S_BS <= S_P2L) && (w_nx + S_BS >= S_P2L) && w_ov2;

  logic [COORD_W-1:0] w_bx_nxt;
  logic [COORD_W-1:0] w_by_nxt;
  logic               w_dx_nxt;
  logic               w_dy_nxt;
  logic               w_relatch;
  logic               w_miss1;
  logic               w_miss2;

  // Vertical and horizontal resolve independently so a wall bounce and a
  // paddle hit on the same tick both take effect.
  always_comb begin
    w_by_nxt = w_ny[COORD_W-1:0];
    w_dy_nxt = r_dy_up;
    if (w_ny <= S_ZERO) begin
      w_by_nxt = '0;
      w_dy_nxt = 1'b0;
    end else if (w_ny >= S_YMAX) begin
      w_by_nxt = S_YMAX[COORD_W-1:0];
      w_dy_nxt = 1'b1;
    end

    w_bx_nxt   = w_nx[COORD_W-1:0];
    w_dx_nxt   = r_dx_left;
    w_relatch  = 1'b0;
    w_miss1    = 1'b0;
    w_miss2    = 1'b0;
    if (w_hit1) begin
      w_bx_nxt  = S_P1R[COORD_W-1:0];
      w_dx_nxt  = 1'b0;
      w_relatch = 1'b1;
    end else if (w_hit2) begin
      w_bx_nxt  = COORD_W'(PADDLE2_L - BALL_SIZE);
      w_dx_nxt  = 1'b1;
      w_relatch = 1'b1;
    end else if (w_nx <= S_ZERO) begin
      w_bx_nxt = '0;
      w_dx_nxt = 1'b1;
      w_miss1  = 1'b1;
    end else if (w_nx >= S_XMAX) begin
      w_bx_nxt = S_XMAX[COORD_W-1:0];
      w_dx_nxt = 1'b0;
      w_miss2  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ball_x  <= BALL_X0;
      r_ball_y  <= BALL_Y0;
      r_p1y     <= PADDLE_Y0;
      r_p2y     <= PADDLE_Y0;
      r_v       <= COORD_W'(BALL_VEL_BASE);
      r_dx_left <= 1'b0;
      r_dy_up   <= 1'b0;
      r_miss1   <= 1'b0;
      r_miss2   <= 1'b0;
    end else begin
      r_miss1 <= 1'b0;
      r_miss2 <= 1'b0;
      if (frame_tick && (r_state != ST_IDLE)) begin
        r_p1y <= w_p1y_nxt;
        r_p2y <= w_p2y_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SERVE;
            r_cnt    <= '0;
            r_ball_x <= BALL_X0;
            r_ball_y <= BALL_Y0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            r_ball_x <= BALL_X0;
            r_ball_y <= BALL_Y0;
            if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              r_state <= ST_PLAY;
              r_cnt   <= '0;
              r_v     <= w_lvl_v;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            r_ball_x  <= w_bx_nxt;
            r_ball_y  <= w_by_nxt;
            r_dx_left <= w_dx_nxt;
            r_dy_up   <= w_dy_nxt;
            if (w_relatch) r_v <= w_lvl_v;
            if (w_miss1 || w_miss2) begin
              r_state <= ST_MISS;
              r_cnt   <= '0;
              r_miss1 <= w_miss1;
              r_miss2 <= w_miss2;
            end
          end
        end
        default: begin
          if (frame_tick) begin
            if (r_cnt == CNT_W'(MISS_FRAMES - 1)) begin
              r_state  <= ST_SERVE;
              r_cnt    <= '0;
              r_ball_x <= BALL_X0;
              r_ball_y <= BALL_Y0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ball_x    = r_ball_x;
  assign ball_y    = r_ball_y;
  assign paddle1_y = r_p1y;
  assign paddle2_y = r_p2y;
  assign miss1     = r_miss1;
  assign miss2     = r_miss2;
  assign state     = r_state;

endmodule

// File: tb/tb_pong_physics.sv
// Bench for pong_physics: a game-rule model (plain integer arithmetic with
// signed direction/speed and countdown timers) is stepped alongside the DUT
// and every output is compared each cycle; a directed opening pins the model
// with hand-computed positions, then a long randomized run follows.
module tb_pong_physics;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic [3:0]    level = '0;
  logic [CW-1:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic          miss1, miss2;
  logic [1:0]    state;

  pong_physics dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2), .level(level),
    .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .miss1(miss1), .miss2(miss2), .state(state)
  );

  always #5 clk = ~clk;

  // Model state: state code, ball, direction as +1/-1, speed, paddles,
  // remaining ticks of the current serve/miss hold, miss pulses.
  int m_st = 0, m_bx = 315, m_by = 235, m_dx = 1, m_dy = 1, m_v = 4;
  int m_p1 = 215, m_p2 = 215, m_left = 0, m_m1 = 0, m_m2 = 0;
  int n_checks = 0, n_fail = 0;

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int vel(input int lvl);
    return (4 + lvl > 12) ? 12 : 4 + lvl;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_play(input int op1, input int op2);
    int nx, ny, ox, oy;
    bit ov1, ov2;
    ox = m_bx; oy = m_by;
    nx = ox + m_dx * m_v;
    ny = oy + m_dy * m_v;
    if (ny <= 0) begin m_by = 0; m_dy = 1; end
    else if (ny >= 470) begin m_by = 470; m_dy = -1; end
    else m_by = ny;
    ov1 = (oy + 10 > op1) && (oy < op1 + 50);
    ov2 = (oy + 10 > op2) && (oy < op2 + 50);
    if (m_dx < 0 && ox >= 100 && nx <= 100 && ov1) begin
      m_bx = 100; m_dx = 1; m_v = vel(int'(level));
    end else if (m_dx > 0 && ox + 10 <= 540 && nx + 10 >= 540 && ov2) begin
      m_bx = 530; m_dx = -1; m_v = vel(int'(level));
    end else if (nx <= 0) begin
      m_bx = 0; m_dx = -1; m_m1 = 1; m_st = 3; m_left = 60;
    end else if (nx >= 630) begin
      m_bx = 630; m_dx = 1; m_m2 = 1; m_st = 3; m_left = 60;
    end else begin
      m_bx = nx;
    end
  endtask

  task automatic model_step();
    int op1, op2;
    if (rst) begin
      m_st = 0; m_bx = 315; m_by = 235; m_p1 = 215; m_p2 = 215;
      m_dx = 1; m_dy = 1; m_m1 = 0; m_m2 = 0; m_left = 0;
      return;
    end
    m_m1 = 0; m_m2 = 0;
    if (m_st == 0) begin
      if (start) begin m_st = 1; m_left = 30; m_bx = 315; m_by = 235; end
      return;
    end
    if (!frame_tick) return;
    op1 = m_p1; op2 = m_p2;
    m_p1 = clampi(m_p1 + 8 * (int'(down1) - int'(up1)), 0, 430);
    m_p2 = clampi(m_p2 + 8 * (int'(down2) - int'(up2)), 0, 430);
    case (m_st)
      1: begin
        m_bx = 315; m_by = 235;
        m_left--;
        if (m_left == 0) begin m_st = 2; m_v = vel(int'(level)); end
      end
      2: model_play(op1, op2);
      default: begin
        m_left--;
        if (m_left == 0) begin m_st = 1; m_left = 30; m_bx = 315; m_by = 235; end
      end
    endcase
  endtask

  task automatic compare_all();
    check("ball_x", int'(ball_x), m_bx);
    check("ball_y", int'(ball_y), m_by);
    check("paddle1_y", int'(paddle1_y), m_p1);
    check("paddle2_y", int'(paddle2_y), m_p2);
    check("miss1", int'(miss1), m_m1);
    check("miss2", int'(miss2), m_m2);
    check("state", int'(state), m_st);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ball_x"}, int'(ball_x), 315);
    check({tag, "_ball_y"}, int'(ball_y), 235);
    check({tag, "_p1"}, int'(paddle1_y), 215);
    check({tag, "_p2"}, int'(paddle2_y), 215);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_miss"}, int'(miss1) + int'(miss2), 0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check_reset_values("reset");

    // Start without a tick; paddles frozen in IDLE even with buttons held
    start = 1'b1; up1 = 1'b1;
    cycle();
    start = 1'b0;
    check("start_state", int'(state), 1);
    check("idle_p1_frozen", int'(paddle1_y), 215);

    // Serve: 30 ticks with both paddles driven up (p2 ends at 0, out of the ball's way)
    up2 = 1'b1; frame_tick = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (i == 26) check("p1_near_top", int'(paddle1_y), 7);
      if (i == 27) check("p1_clamp_top", int'(paddle1_y), 0);
      if (i == 29) check("serve_tick29_state", int'(state), 1);
      if (i == 30) begin
        check("serve_tick30_state", int'(state), 2);
        check("serve_ball_x", int'(ball_x), 315);
      end
    end
    up1 = 1'b0; up2 = 1'b0;

    // Play rightward at v=4: wall bounce at 470, paddle2 at 0 missed, miss2 at tick 79
    for (int k = 1; k <= 80; k++) begin
      cycle();
      if (k == 1) begin
        check("first_play_x", int'(ball_x), 319);
        check("first_play_y", int'(ball_y), 239);
      end
      if (k == 59) check("wall_clamp_y", int'(ball_y), 470);
      if (k == 60) check("wall_bounce_y", int'(ball_y), 466);
      if (k == 78) check("pre_miss_state", int'(state), 2);
      if (k == 79) begin
        check("miss_state", int'(state), 3);
        check("miss_ball_x", int'(ball_x), 630);
        check("miss2_pulse", int'(miss2), 1);
        check("miss1_quiet", int'(miss1), 0);
      end
      if (k == 80) check("miss2_one_cycle", int'(miss2), 0);
    end

    // k=80 was the first MISS tick; 59 more end the hold
    for (int j = 2; j <= 60; j++) begin
      cycle();
      if (j == 59) check("miss_hold_state", int'(state), 3);
      if (j == 60) begin
        check("reserve_state", int'(state), 1);
        check("reserve_ball_x", int'(ball_x), 315);
        check("reserve_ball_y", int'(ball_y), 235);
      end
    end

    // Both buttons: no movement; then down only clamps at 430
    up1 = 1'b1; down1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("both_pressed_p1", int'(paddle1_y), 0);
    end
    up1 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (i == 53) check("p1_near_bottom", int'(paddle1_y), 424);
      if (i >= 54) check("p1_clamp_bottom", int'(paddle1_y), 430);
    end
    down1 = 1'b0;

    // Reset in the middle of PLAY with a tick on the same cycle
    check("pre_rst_state", int'(state), 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_values("midrst");

    // Randomized play
    for (int c = 0; c < 40000; c++) begin
      rst        = ($urandom_range(0, 4999) == 0);
      frame_tick = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) up1   = ~up1;
      if ($urandom_range(0, 15) == 0) down1 = ~down1;
      if ($urandom_range(0, 15) == 0) up2   = ~up2;
      if ($urandom_range(0, 15) == 0) down2 = ~down2;
      if ($urandom_range(0, 299) == 0) level = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_physics.md
Name: pong_physics

Overview:
- Parametrised Pong game engine: updates ball and two paddle positions once per video frame tick.
- Handles wall bounces, paddle hits and misses, and a serve/miss sequence.
- Ball speed scales with an external level input.
- Sits between the input debouncers/score-timer logic and the VGA renderer; all outputs are top-left pixel coordinates.

Parameters:
H_RES, 640, horizontal resolution; x range 0..H_RES-1
V_RES, 480, vertical resolution; y range 0..V_RES-1
COORD_W, 10, coordinate width in bits
PADDLE1_L, 90, left x of paddle1 (paddle1 right edge = PADDLE1_L+PADDLE_T)
PADDLE2_L, 540, left x of paddle2
PADDLE_T, 10, paddle thickness
PADDLE_LEN, 50, paddle length
BALL_SIZE, 10, ball side length
PADDLE_VEL, 8, paddle pixels per tick
BALL_VEL_BASE, 4, ball pixels per tick per axis at level 0
BALL_VEL_MAX, 12, ball speed ceiling
LEVEL_W, 4, level input width
SERVE_FRAMES, 30, ticks ball is held centred before launch
MISS_FRAMES, 60, ticks ball is frozen after a miss

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame; all motion happens only on cycles with frame_tick=1
start  in  1  leaves IDLE
up1, down1, up2, down2  in  1 each  paddle controls (up = decreasing y)
level  in  LEVEL_W  speed level
ball_x, ball_y  out  COORD_W each  ball top-left
paddle1_y, paddle2_y  out  COORD_W each  paddle top y
miss1, miss2  out  1 each  one-cycle pulse when player1 / player2 misses
state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 MISS

Behaviour:
Reset:
- state=IDLE; ball at centre: ball_x=(H_RES-BALL_SIZE)/2=315, ball_y=(V_RES-BALL_SIZE)/2=235.
- paddle1_y=paddle2_y=(V_RES-PADDLE_LEN)/2=215.
- miss1=miss2=0; dx=+ (right), dy=+ (down); frame counter=0.
- rst mid-game overrides everything in the same cycle.

Output timing:
- All position outputs are registered.
- A frame_tick at cycle N shows new positions at cycle N+1.

FSM:
- IDLE: positions held; start=1 -> SERVE with counter cleared.
- SERVE: ball forced to centre. Counter increments per tick. On the tick where counter reaches SERVE_FRAMES-1 -> PLAY; speed v=min(BALL_VEL_BASE+level, BALL_VEL_MAX) is latched that cycle.
- PLAY: ball moves. A miss -> MISS.
- MISS: ball frozen at its clamped position for MISS_FRAMES ticks -> SERVE.
- start is ignored outside IDLE.

Paddles (SERVE, PLAY and MISS; frozen in IDLE):
- up only: y-=PADDLE_VEL, clamped at 0.
- down only: y+=PADDLE_VEL, clamped at V_RES-PADDLE_LEN (430).
- both or neither pressed: no move.
- Arithmetic uses COORD_W+1-bit signed intermediates, so no wrap-around.

Ball per PLAY tick:
- nx=ball_x±v, ny=ball_y±v, computed in COORD_W+1-bit signed.
- Vertical:
  - ny<=0: ball_y=0, dy=+.
  - ny>=V_RES-BALL_SIZE (470): ball_y=470, dy=-.
  - otherwise ball_y=ny.
- Paddle1 hit (dx=-, ball_x>=PADDLE1_L+PADDLE_T, nx<=PADDLE1_L+PADDLE_T, and ball_y+BALL_SIZE>paddle1_y and ball_y<paddle1_y+PADDLE_LEN):
  - ball_x=PADDLE1_L+PADDLE_T (100), dx=+.
  - v re-latched from current level.
- Paddle2 hit (dx=+, ball_x+BALL_SIZE<=PADDLE2_L, nx+BALL_SIZE>=PADDLE2_L, with the same overlap test against paddle2_y):
  - ball_x=PADDLE2_L-BALL_SIZE (530), dx=-, v re-latched.
- Overlap tests use the paddle position before this tick's paddle update.
- Miss:
  - Else if nx<=0: ball_x=0, miss1=1 for one cycle, next serve dx=- (toward player1).
  - Else if nx>=H_RES-BALL_SIZE (630): ball_x=630, miss2=1, next serve dx=+.
- Otherwise ball_x=nx.
- Wall bounce and paddle hit in the same tick are both applied (corner case).
- A paddle hit takes priority over a miss.
- dy is preserved across serves.

Level: changes take effect only at the next latch point (serve launch or paddle hit).

Test Plan:
- Reset, start, 30 ticks -> state=PLAY on tick 30; first PLAY tick (level=0) moves ball from (315,235) to (319,239).
- Paddle1 up held 30 ticks from 215 -> reaches 7 then clamps at 0; down+up held together -> no movement; down held -> clamps at 430.
- Ball dx=-, ball_x=104, v=4, ball_y=220, paddle1_y=215 -> ball_x=100, dx=+; with level=9 the new v=min(13,12)=12.
- Paddle1_y=0, ball_y=300, ball moving left -> ball passes paddle, ball_x clamps to 0, miss1 pulses exactly one cycle, state=MISS; after 60 ticks state=SERVE with ball at (315,235); the launch is leftward.
- Ball at ball_y=2, dy=-, v=4 -> ball_y=0, dy=+; next tick ball_y=4.
- Assert rst mid-PLAY with frame_tick=1 on the same cycle -> next cycle shows reset values, state=IDLE, no miss pulse.
